crossbar_rr_arbiter: RTL and testbench

Registered round-robin arbiter for one slave port of the master/slave crossbar; one instance per slave. It takes per-master requests already decoded to this slave and grants exactly one master at a time. The grant is held for the whole transaction, until the slave acks or the requester withdraws. The one-hot grant drives the crossbar's AND-OR address/wdata/cmd/rdata muxes and routes the slave ack back to the winning master.

---
 rtl/crossbar_rr_arbiter_if.sv | 28 ++
 rtl/crossbar_rr_arbiter.sv | 117 +++++++++++
 tb/tb_crossbar_rr_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_rr_arbiter_if.sv
// Handshake bundle between crossbar masters and one slave-port arbiter.
// Carries the decoded requests, the slave ack and the arbiter's grant outputs.
interface crossbar_rr_arbiter_if #(
  parameter int N_MASTERS = 4
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] req;
  logic                 slave_ack;
  logic [N_MASTERS-1:0] grant;
  logic [IW-1:0]        grant_idx;
  logic                 slave_req;
  logic [N_MASTERS-1:0] master_ack;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, slave_ack,
    input  grant, grant_idx, slave_req,
    input  master_ack, busy, timeout_err
  );

  modport slave (
    input  req, slave_ack,
    output grant, grant_idx, slave_req,
    output master_ack, busy, timeout_err
  );
endinterface

// File: rtl/crossbar_rr_arbiter.sv
// Registered round-robin arbiter for one crossbar slave port.
// Optional BUSY watchdog: define CROSSBAR_ARB_TIMEOUT_EN.
module crossbar_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  crossbar_rr_arbiter_if.slave    bus
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || N_MASTERS > 16 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
    $error("crossbar_rr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        last_q;
  logic                 busy_q;

  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic                 hold;

  assign hold = bus.req[idx_q];

  // Round-robin pick: first request at last+1, last+2, ... with wrap.
  always_comb begin
    int k;
    logic [IW-1:0] kk;
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      k = int'(last_q) + 1 + i;
      if (k >= N_MASTERS) k = k - N_MASTERS;
      kk = IW'(k);
      if (!win_vld && bus.req[kk]) begin
        win_vld = 1'b1;
        win_idx = kk;
      end
    end
  end

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        terr_q;
`endif

  // Arbitration FSM; every externally visible state bit is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      busy_q  <= 1'b0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      terr_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q <= BUSY;
            grant_q <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
            idx_q   <= win_idx;
            last_q  <= win_idx;
            busy_q  <= 1'b1;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.slave_ack || !hold) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
`ifdef CROSSBAR_ARB_TIMEOUT_EN
          else if (cnt_q == 16'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_idx  = idx_q;
  assign bus.busy       = busy_q;
  assign bus.slave_req  = busy_q & hold;
  assign bus.master_ack = grant_q & {N_MASTERS{bus.slave_ack}};
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_crossbar_rr_arbiter.sv
// Bench for crossbar_rr_arbiter: directed vectors, hand-computed checks
// and a transaction-level model compared on every falling edge.
module tb_crossbar_rr_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  crossbar_rr_arbiter_if #(.N_MASTERS(N)) bus ();

  crossbar_rr_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: owner = -1 when idle; age = BUSY cycles elapsed without ack.
  int m_owner;
  int m_last;
  int m_age;
  bit m_terr;

  always @(posedge clk or negedge rst_n) begin
    int best;
    int bestd;
    int d;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = N - 1;
      m_age   = 0;
      m_terr  = 0;
    end else begin
      m_terr = 0;
      if (m_owner < 0) begin
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (bus.req[i] && d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
        if (best >= 0) begin
          m_owner = best;
          m_last  = best;
          m_age   = 0;
        end
      end else if (bus.slave_ack) begin
        m_owner = -1;
      end else if (!bus.req[m_owner]) begin
        m_owner = -1;
      end else begin
        m_age++;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
        if (m_age == TO) begin
          m_owner = -1;
          m_terr  = 1;
        end
`endif
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] em;
    logic         es;
    eg = '0;
    em = '0;
    es = 1'b0;
    if (m_owner >= 0) begin
      eg = N'(1) << m_owner;
      es = bus.req[m_owner];
      if (bus.slave_ack) em = eg;
      chk("cmp_idx", bus.grant_idx, m_owner);
    end
    chk("cmp_grant", bus.grant, eg);
    chk("cmp_busy", bus.busy, m_owner >= 0);
    chk("cmp_sreq", bus.slave_req, es);
    chk("cmp_mack", bus.master_ack, em);
    chk("cmp_terr", bus.timeout_err, m_terr);
  end

  logic [3:0] rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.slave_ack = 1'b0;
    repeat (3) step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sreq", bus.slave_req, 0);
    chk("rst_mack", bus.master_ack, 0);
    chk("rst_terr", bus.timeout_err, 0);

    rst_n   = 1'b1;
    bus.req = 4'b1111;
    step();
    chk("first_grant", bus.grant, 4'b0001);

    for (int t = 0; t < 5; t++) begin
      chk("rot_grant", bus.grant, rot[t]);
      chk("rot_sreq", bus.slave_req, 1);
      step();
      bus.slave_ack = 1'b1;
      #1 chk("rot_mack", bus.master_ack, rot[t]);
      step();
      bus.slave_ack = 1'b0;
      if (t == 4) bus.req = '0;
      chk("rot_idle", bus.grant, 0);
      step();
    end

    bus.req = 4'b0100;
    step();
    chk("g2_grant", bus.grant, 4'b0100);
    chk("g2_idx", bus.grant_idx, 2);
    bus.slave_ack = 1'b1;
    #1 chk("ack_route", bus.master_ack, 4'b0100);
    step();
    bus.slave_ack = 1'b0;
    bus.req       = 4'b0011;
    step();
    chk("wrap_grant", bus.grant, 4'b0001);

    bus.req = 4'b0010;
    #1 chk("wd0_mack", bus.master_ack, 0);
    chk("wd0_sreq", bus.slave_req, 0);
    step();
    chk("wd0_idle", bus.grant, 0);
    step();
    chk("skip_grant", bus.grant, 4'b0010);

    bus.req = '0;
    step();
    chk("wd1_busy", bus.busy, 0);
    bus.req = 4'b0011;
    step();
    chk("after_wd_grant", bus.grant, 4'b0001);

    bus.req       = '0;
    bus.slave_ack = 1'b1;
    #1 chk("ack_wd_mack", bus.master_ack, 4'b0001);
    step();
    bus.slave_ack = 1'b0;
    chk("ack_wd_idle", bus.grant, 0);

    bus.slave_ack = 1'b1;
    #1 chk("stray_mack", bus.master_ack, 0);
    step();
    bus.slave_ack = 1'b0;
    chk("stray_busy", bus.busy, 0);

    bus.req = 4'b0100;
    step();
    chk("to_grant_on", bus.grant, 4'b0100);
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    n = 0;
    while (!bus.timeout_err && n < 20) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_grant_off", bus.grant, 0);
    bus.req = '0;
    step();
    chk("to_pulse_end", bus.timeout_err, 0);
`else
    n = 0;
    repeat (100) begin
      step();
      n++;
    end
    chk("nto_grant", bus.grant, 4'b0100);
    chk("nto_terr", bus.timeout_err, 0);
    bus.slave_ack = 1'b1;
    step();
    bus.slave_ack = 1'b0;
    bus.req       = '0;
    step();
`endif

    bus.req = 4'b1000;
    step();
    chk("pre_rst_grant", bus.grant, 4'b1000);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_grant", bus.grant, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_sreq", bus.slave_req, 0);
    chk("arst_idx", bus.grant_idx, 0);
    bus.slave_ack = 1'b1;
    #1 chk("arst_mack", bus.master_ack, 0);
    bus.slave_ack = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    step();
    chk("post_rst_grant", bus.grant, 4'b0001);
    bus.req       = '0;
    bus.slave_ack = 1'b1;
    step();
    bus.slave_ack = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
